// File: rtl/cdb_wb_arbiter.sv
// Writeback / CDB arbiter: each execute unit has a small private result queue, and a
// round-robin arbiter drains one queue head per cycle onto the shared broadcast slot.
// A flush from the ROB discards everything still queued.
module cdb_wb_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int DEPTH     = 2,
   parameter int ROB_IDX_W = 3,
   parameter int PAYLOAD_W = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx,
   input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
   output logic                           cdb_valid,
   output logic [$clog2(NUM_REQ)-1:0]     cdb_src,
   output logic [ROB_IDX_W-1:0]           cdb_rob_idx,
   output logic [PAYLOAD_W-1:0]           cdb_payload,
   output logic [15:0]                    conflict_cnt
);

   localparam int SRC_W = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_REQ - 1);

   // Queue control state (reset) and queue storage (not reset; guarded by count).
   logic [CNT_W-1:0]     count [NUM_REQ];
   logic [PTR_W-1:0]     head  [NUM_REQ];
   logic [PTR_W-1:0]     tail  [NUM_REQ];
   logic [ROB_IDX_W-1:0] rob_mem [NUM_REQ][DEPTH];
   logic [PAYLOAD_W-1:0] pay_mem [NUM_REQ][DEPTH];
   logic [SRC_W-1:0]     rr_ptr;

   logic [NUM_REQ-1:0]   nonempty;
   logic [NUM_REQ-1:0]   push;
   logic [NUM_REQ-1:0]   pop;
   logic [SRC_W-1:0]     grant;
   logic                 any_pending;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // True when at least two bits of the vector are set.
   function automatic logic multi_set(input logic [NUM_REQ-1:0] v);
      return |(v & (v - 1'b1));
   endfunction

   // Occupancy flags, accept handshake and push qualification per unit.
   always_comb begin
      nonempty  = '0;
      req_ready = '0;
      push      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         nonempty[i]  = (count[i] != '0);
         req_ready[i] = (count[i] != DEPTH_C) && !flush;
         push[i]      = req_valid[i] && req_ready[i];
      end
   end

   // Round-robin scan starting at rr_ptr; first non-empty queue wins.
   always_comb begin
      int idx;
      idx         = 0;
      any_pending = 1'b0;
      grant       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any_pending && nonempty[idx]) begin
            any_pending = 1'b1;
            grant       = SRC_W'(idx);
         end
      end
   end

   // Broadcast the granted head; all fields are zero when nothing is broadcast.
   always_comb begin
      cdb_valid   = any_pending && !flush;
      cdb_src     = '0;
      cdb_rob_idx = '0;
      cdb_payload = '0;
      pop         = '0;
      if (cdb_valid) begin
         cdb_src     = grant;
         cdb_rob_idx = rob_mem[grant][head[grant]];
         cdb_payload = pay_mem[grant][head[grant]];
         pop[grant]  = 1'b1;
      end
   end

   // Queue pointers/counts, round-robin pointer and conflict counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            count[i] <= '0;
            head[i]  <= '0;
            tail[i]  <= '0;
         end
         rr_ptr       <= '0;
         conflict_cnt <= '0;
      end else if (flush) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            count[i] <= '0;
            head[i]  <= '0;
            tail[i]  <= '0;
         end
         rr_ptr <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) tail[i] <= tail[i] + 1'b1;
            if (pop[i])  head[i] <= head[i] + 1'b1;
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + 1'b1;
               2'b01:   count[i] <= count[i] - 1'b1;
               default: count[i] <= count[i];
            endcase
         end
         if (cdb_valid) rr_ptr <= (grant == LAST_SRC) ? '0 : grant + 1'b1;
         if (multi_set(nonempty)) conflict_cnt <= sat_inc16(conflict_cnt);
      end
   end

   // Result storage written at the tail slot on an accepted push.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (push[i]) begin
            rob_mem[i][tail[i]] <= req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            pay_mem[i][tail[i]] <= req_payload[i*PAYLOAD_W +: PAYLOAD_W];
         end
      end
   end

   // A full queue never accepts a push.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_chk
      a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
         push[g] |-> (count[g] != DEPTH_C));
   end

   // Only one queue is popped per cycle.
   a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(pop));

   // A broadcast always comes from a queue that holds a result.
   a_grant_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
      cdb_valid |-> nonempty[grant]);

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Bench for cdb_wb_arbiter: a queue-based reference model of the three unit queues and
// the round-robin pointer, checked every cycle, plus directed scenarios with literal
// expectations and a randomized phase with occasional flushes and a mid-run reset.
module tb_cdb_wb_arbiter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         flush = 1'b0;
   logic [2:0]   req_valid = '0;
   logic [2:0]   req_ready;
   logic [8:0]   req_rob_idx = '0;
   logic [191:0] req_payload = '0;
   logic         cdb_valid;
   logic [1:0]   cdb_src;
   logic [2:0]   cdb_rob_idx;
   logic [63:0]  cdb_payload;
   logic [15:0]  conflict_cnt;

   int errors = 0;
   int checks = 0;

   // Reference model: per-unit FIFO of {rob_idx, payload}, rr pointer, conflict count.
   logic [66:0] mq [3][$];
   int          rr  = 0;
   int          mcc = 0;

   // Observed values captured in the most recent step.
   logic        o_valid;
   logic [1:0]  o_src;
   logic [2:0]  o_rob;
   logic [2:0]  o_ready;
   logic [15:0] o_cc;

   cdb_wb_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_rob_idx  (req_rob_idx),
      .req_payload  (req_payload),
      .cdb_valid    (cdb_valid),
      .cdb_src      (cdb_src),
      .cdb_rob_idx  (cdb_rob_idx),
      .cdb_payload  (cdb_payload),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 3; i++) mq[i].delete();
      rr = 0;
   endtask

   // One clock cycle: drive at the falling edge, check outputs against the model,
   // then advance the model over the following rising edge.
   task automatic step(input logic [2:0] v, input logic fl,
                       input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2);
      logic [2:0]  e_ready;
      logic        e_valid;
      logic [66:0] h;
      logic [63:0] pv [3];
      logic [2:0]  rv [3];
      int          g;
      int          n;
      int          idx;
      @(negedge clk);
      rv[0] = r0; rv[1] = r1; rv[2] = r2;
      for (int i = 0; i < 3; i++) pv[i] = {$urandom, $urandom};
      req_valid   = v;
      flush       = fl;
      req_rob_idx = {r2, r1, r0};
      req_payload = {pv[2], pv[1], pv[0]};
      #1;
      e_valid = 1'b0;
      e_ready = '0;
      g = 0;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         e_ready[i] = (mq[i].size() < 2) && !fl;
         if (mq[i].size() > 0) n++;
      end
      if (!fl) begin
         for (int k = 0; k < 3; k++) begin
            idx = (rr + k) % 3;
            if (!e_valid && mq[idx].size() > 0) begin
               e_valid = 1'b1;
               g = idx;
            end
         end
      end
      o_valid = cdb_valid;
      o_src   = cdb_src;
      o_rob   = cdb_rob_idx;
      o_ready = req_ready;
      o_cc    = conflict_cnt;
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("cdb_valid", 64'(cdb_valid), 64'(e_valid));
      if (e_valid) begin
         h = mq[g][0];
         chk("cdb_src", 64'(cdb_src), 64'(g));
         chk("cdb_rob_idx", 64'(cdb_rob_idx), 64'(h[66:64]));
         chk("cdb_payload", cdb_payload, h[63:0]);
      end else begin
         chk("cdb_src_idle", 64'(cdb_src), 64'd0);
         chk("cdb_rob_idle", 64'(cdb_rob_idx), 64'd0);
         chk("cdb_pay_idle", cdb_payload, 64'd0);
      end
      chk("conflict_cnt", 64'(conflict_cnt), 64'(mcc));
      if (fl) begin
         model_clear();
      end else begin
         if (n >= 2 && mcc < 65535) mcc++;
         if (e_valid) begin
            void'(mq[g].pop_front());
            rr = (g + 1) % 3;
         end
         for (int i = 0; i < 3; i++)
            if (v[i] && e_ready[i]) mq[i].push_back({rv[i], pv[i]});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(3'b000, 1'b0, 3'd0, 3'd0, 3'd0);
   endtask

   initial begin
      int cc0;
      // Reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", 64'(req_ready), 64'h7);
      chk("rst_valid", 64'(cdb_valid), 64'd0);
      chk("rst_src", 64'(cdb_src), 64'd0);
      chk("rst_rob", 64'(cdb_rob_idx), 64'd0);
      chk("rst_pay", cdb_payload, 64'd0);
      chk("rst_cc", 64'(conflict_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single ALU push, broadcast exactly one cycle later, rr moves to 1
      step(3'b001, 1'b0, 3'd5, 3'd0, 3'd0);
      chk("t1_no_bypass", 64'(o_valid), 64'd0);
      step(3'b000, 1'b0, 3'd0, 3'd0, 3'd0);
      chk("t1_valid", 64'(o_valid), 64'd1);
      chk("t1_src", 64'(o_src), 64'd0);
      chk("t1_rob", 64'(o_rob), 64'd5);
      step(3'b011, 1'b0, 3'd4, 3'd6, 3'd0);
      chk("t1_once", 64'(o_valid), 64'd0);
      step(3'b000, 1'b0, 3'd0, 3'd0, 3'd0);
      chk("t1_rr_src", 64'(o_src), 64'd1);
      chk("t1_rr_rob", 64'(o_rob), 64'd6);
      step(3'b000, 1'b0, 3'd0, 3'd0, 3'd0);
      chk("t1_rr_src2", 64'(o_src), 64'd0);
      chk("t1_rr_rob2", 64'(o_rob), 64'd4);

      // 2: all three push together with rr=0
      step(3'b000, 1'b1, 3'd0, 3'd0, 3'd0);
      step(3'b111, 1'b0, 3'd1, 3'd2, 3'd3);
      cc0 = int'(o_cc);
      step(3'b000, 1'b0, 3'd0, 3'd0, 3'd0);
      chk("t2_src0", 64'(o_src), 64'd0);
      chk("t2_rob0", 64'(o_rob), 64'd1);
      step(3'b000, 1'b0, 3'd0, 3'd0, 3'd0);
      chk("t2_src1", 64'(o_src), 64'd1);
      chk("t2_rob1", 64'(o_rob), 64'd2);
      step(3'b000, 1'b0, 3'd0, 3'd0, 3'd0);
      chk("t2_src2", 64'(o_src), 64'd2);
      chk("t2_rob2", 64'(o_rob), 64'd3);
      chk("t2_conflict", 64'(int'(o_cc) - cc0), 64'd2);
      idle(1);

      // 3: continuous traffic from all units, grants rotate 0,1,2
      step(3'b000, 1'b1, 3'd0, 3'd0, 3'd0);
      for (int k = 0; k < 9; k++) begin
         step(3'b111, 1'b0, 3'($urandom), 3'($urandom), 3'($urandom));
         if (k >= 1) chk("t3_rotate", 64'(o_src), 64'((k - 1) % 3));
      end
      idle(8);

      // 4: MUL queue full, ready returns the cycle after the pop
      step(3'b000, 1'b1, 3'd0, 3'd0, 3'd0);
      step(3'b011, 1'b0, 3'd1, 3'd2, 3'd0);
      step(3'b011, 1'b0, 3'd3, 3'd4, 3'd0);
      step(3'b010, 1'b0, 3'd0, 3'd5, 3'd0);
      chk("t4_full_ready", 64'(o_ready[1]), 64'd0);
      chk("t4_pop_src", 64'(o_src), 64'd1);
      step(3'b010, 1'b0, 3'd0, 3'd6, 3'd0);
      chk("t4_ready_back", 64'(o_ready[1]), 64'd1);
      idle(6);

      // 5: four queued results discarded by a one-cycle flush
      step(3'b111, 1'b0, 3'd1, 3'd2, 3'd3);
      step(3'b011, 1'b0, 3'd4, 3'd5, 3'd0);
      step(3'b000, 1'b1, 3'd0, 3'd0, 3'd0);
      chk("t5_flush_valid", 64'(o_valid), 64'd0);
      chk("t5_flush_ready", 64'(o_ready), 64'd0);
      step(3'b000, 1'b0, 3'd0, 3'd0, 3'd0);
      chk("t5_after_valid", 64'(o_valid), 64'd0);
      chk("t5_after_ready", 64'(o_ready), 64'h7);
      step(3'b011, 1'b0, 3'd6, 3'd7, 3'd0);
      step(3'b000, 1'b0, 3'd0, 3'd0, 3'd0);
      chk("t5_rr_zero", 64'(o_src), 64'd0);
      idle(2);

      // 6: asynchronous reset in the middle of a burst
      step(3'b111, 1'b0, 3'd1, 3'd2, 3'd3);
      step(3'b111, 1'b0, 3'd4, 3'd5, 3'd6);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_valid", 64'(cdb_valid), 64'd0);
      chk("t6_cc", 64'(conflict_cnt), 64'd0);
      chk("t6_ready", 64'(req_ready), 64'h7);
      model_clear();
      mcc = 0;
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step(3'b000, 1'b0, 3'd0, 3'd0, 3'd0);
      chk("t6_empty", 64'(o_valid), 64'd0);
      chk("t6_cc_after", 64'(o_cc), 64'd0);

      // Randomized traffic with occasional flushes
      for (int k = 0; k < 3000; k++)
         step(3'($urandom), ($urandom_range(0, 19) == 0),
              3'($urandom), 3'($urandom), 3'($urandom));
      idle(8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
